// File: rtl/regseq_pkg.sv
// Shared encodings for the register-bank command sequencer.
// Holds command ops, bank ops and the sequencer state enum.
package regseq_pkg;

  localparam logic [1:0] OP_IN   = 2'd0;
  localparam logic [1:0] OP_MOVE = 2'd1;
  localparam logic [1:0] OP_OUT  = 2'd2;
  localparam logic [1:0] OP_NOP  = 2'd3;

  localparam logic [1:0] RB_WRITE = 2'd0;
  localparam logic [1:0] RB_READ  = 2'd1;
  localparam logic [1:0] RB_IDLE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_MOVE_WR
  } state_t;

endpackage

// File: rtl/regseq_shadow.sv
// 8x16 shadow copy of the register bank written by the sequencer.
// One write port, one combinational read port; clears on reset.
module regseq_shadow
  import regseq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem [8];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/reg_cmd_sequencer.sv
// Command initiator for the 8x16 register bank (IN/MOVE/OUT/NOP).
// Define REGSEQ_SHADOW_EN to serve MOVE/OUT reads from a shadow copy.
module reg_cmd_sequencer
  import regseq_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_src,
  input  logic [2:0]  cmd_dst,
  input  logic [15:0] cmd_data,
  output logic [2:0]  rb_code,
  output logic [15:0] rb_data,
  output logic [1:0]  rb_op,
  output logic        rb_enable,
  input  logic [15:0] rb_out,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic [15:0] cmd_count
);

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t      state, nxt_state;
  logic [2:0]  cnt, nxt_cnt;
  logic [1:0]  q_op, nxt_q_op;
  logic [2:0]  q_src, nxt_q_src;
  logic [2:0]  q_dst, nxt_q_dst;
  logic [15:0] tmp, nxt_tmp;
  logic [2:0]  nxt_code;
  logic [15:0] nxt_data;
  logic [1:0]  nxt_op;
  logic        nxt_en;
  logic        nxt_res_valid;
  logic [15:0] nxt_res_data;
  logic [15:0] nxt_count;
  logic        accept;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef REGSEQ_SHADOW_EN
  logic [15:0] sh_rdata;

  regseq_shadow u_shadow (
    .clock (clock),
    .reset (reset),
    .we    (nxt_op == RB_WRITE),
    .waddr (nxt_code),
    .wdata (nxt_data),
    .raddr (cmd_src),
    .rdata (sh_rdata)
  );
`endif

  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_q_op      = q_op;
    nxt_q_src     = q_src;
    nxt_q_dst     = q_dst;
    nxt_tmp       = tmp;
    nxt_code      = 3'd0;
    nxt_data      = 16'd0;
    nxt_op        = RB_IDLE;
    nxt_en        = 1'b0;
    nxt_res_valid = 1'b0;
    nxt_res_data  = res_data;
    nxt_count     = cmd_count;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          nxt_count = cmd_count + 16'd1;
          nxt_q_op  = cmd_op;
          nxt_q_src = cmd_src;
          nxt_q_dst = cmd_dst;
          unique case (cmd_op)
            OP_IN: begin
              nxt_state = ST_WRITE;
              nxt_op    = RB_WRITE;
              nxt_code  = cmd_dst;
              nxt_data  = cmd_data;
            end
`ifdef REGSEQ_SHADOW_EN
            OP_MOVE: begin
              nxt_state = ST_MOVE_WR;
              nxt_tmp   = sh_rdata;
              nxt_op    = RB_WRITE;
              nxt_code  = cmd_dst;
              nxt_data  = sh_rdata;
            end
            OP_OUT: begin
              nxt_res_valid = 1'b1;
              nxt_res_data  = sh_rdata;
            end
`else
            OP_MOVE, OP_OUT: begin
              nxt_state = ST_READ;
              nxt_cnt   = LAT_M1;
              nxt_op    = RB_READ;
              nxt_en    = 1'b1;
              nxt_code  = cmd_src;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_READ: begin
        if (cnt == 3'd0) begin
          // final read edge: rb_out is valid now
          if (q_op == OP_MOVE) begin
            nxt_state = ST_MOVE_WR;
            nxt_tmp   = rb_out;
            nxt_op    = RB_WRITE;
            nxt_code  = q_dst;
            nxt_data  = rb_out;
          end else begin
            nxt_state     = ST_IDLE;
            nxt_res_valid = 1'b1;
            nxt_res_data  = rb_out;
          end
        end else begin
          nxt_cnt  = cnt - 3'd1;
          nxt_op   = RB_READ;
          nxt_en   = 1'b1;
          nxt_code = q_src;
        end
      end
      ST_WRITE, ST_MOVE_WR: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      q_op      <= OP_NOP;
      q_src     <= '0;
      q_dst     <= '0;
      tmp       <= '0;
      rb_code   <= '0;
      rb_data   <= '0;
      rb_op     <= RB_IDLE;
      rb_enable <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      cmd_count <= '0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      q_op      <= nxt_q_op;
      q_src     <= nxt_q_src;
      q_dst     <= nxt_q_dst;
      tmp       <= nxt_tmp;
      rb_code   <= nxt_code;
      rb_data   <= nxt_data;
      rb_op     <= nxt_op;
      rb_enable <= nxt_en;
      res_valid <= nxt_res_valid;
      res_data  <= nxt_res_data;
      cmd_count <= nxt_count;
    end
  end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed bench for reg_cmd_sequencer: one RD_LAT=1 and one RD_LAT=3 instance.
// sel picks which instance receives commands and is observed.
module tb_reg_cmd_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel   = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op   = 2'd3;
  logic [2:0]  cmd_src  = 3'd0;
  logic [2:0]  cmd_dst  = 3'd0;
  logic [15:0] cmd_data = 16'd0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  logic        rdy1, rdy3, en1, en3, rv1, rv3;
  logic [2:0]  code1, code3;
  logic [15:0] data1, data3, out1, out3, rd1, rd3, cnt1, cnt3;
  logic [1:0]  op1, op3;
  logic [15:0] mem1 [8];
  logic [15:0] mem3 [8];
  int          wr1 = 0;
  int          wr3 = 0;

  reg_cmd_sequencer #(.RD_LAT(1)) dut1 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid && sel), .cmd_ready(rdy1),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_data(cmd_data),
    .rb_code(code1), .rb_data(data1), .rb_op(op1),
    .rb_enable(en1), .rb_out(out1),
    .res_valid(rv1), .res_data(rd1), .cmd_count(cnt1)
  );

  reg_cmd_sequencer #(.RD_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid && !sel), .cmd_ready(rdy3),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_data(cmd_data),
    .rb_code(code3), .rb_data(data3), .rb_op(op3),
    .rb_enable(en3), .rb_out(out3),
    .res_valid(rv3), .res_data(rd3), .cmd_count(cnt3)
  );

  // bank models
  assign out1 = (en1 && op1 == 2'd1) ? mem1[code1] : 16'hDEAD;
  assign out3 = (en3 && op3 == 2'd1) ? mem3[code3] : 16'hDEAD;

  always @(posedge clock) begin
    if (op1 == 2'd0) begin
      mem1[code1] <= data1;
      wr1 <= wr1 + 1;
    end
    if (op3 == 2'd0) begin
      mem3[code3] <= data3;
      wr3 <= wr3 + 1;
    end
  end

  logic        o_rdy, o_en, o_rv;
  logic [2:0]  o_code;
  logic [15:0] o_data, o_rd, o_cnt;
  logic [1:0]  o_op;

  assign o_rdy  = sel ? rdy1  : rdy3;
  assign o_en   = sel ? en1   : en3;
  assign o_rv   = sel ? rv1   : rv3;
  assign o_code = sel ? code1 : code3;
  assign o_data = sel ? data1 : data3;
  assign o_rd   = sel ? rd1   : rd3;
  assign o_cnt  = sel ? cnt1  : cnt3;
  assign o_op   = sel ? op1   : op3;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".rdy"},  32'(o_rdy),  32'd1);
    chk({tag, ".op"},   32'(o_op),   32'd3);
    chk({tag, ".en"},   32'(o_en),   32'd0);
    chk({tag, ".code"}, 32'(o_code), 32'd0);
    chk({tag, ".data"}, 32'(o_data), 32'd0);
  endtask

  // called at a negedge with ready high; returns at the negedge of cycle k
  task automatic issue(input logic [1:0] op, input logic [2:0] src,
                       input logic [2:0] dst, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_data  = d;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    cmd_data  = 16'hFFFF;
  endtask

  int c0;
  int w0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem1[i] = 16'd0;
      mem3[i] = 16'd0;
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;

    sel = 1'b1;
    chk_idle("rst1");
    chk("rst1.rv", 32'(o_rv), 32'd0);
    chk("rst1.cnt", 32'(o_cnt), 32'd0);
    sel = 1'b0;
    chk_idle("rst3");
    chk("rst3.rd", 32'(o_rd), 32'd0);

    // IN R0=77
    sel = 1'b1;
    issue(2'd0, 3'd0, 3'd0, 16'd77);
    chk("in.op", 32'(o_op), 32'd0);
    chk("in.code", 32'(o_code), 32'd0);
    chk("in.data", 32'(o_data), 32'd77);
    chk("in.rdy", 32'(o_rdy), 32'd0);
    @(negedge clock);
    chk("in.op1", 32'(o_op), 32'd3);
    chk("in.rdy1", 32'(o_rdy), 32'd1);
    chk("in.cnt", 32'(o_cnt), 32'd1);
    chk("in.mem", 32'(mem1[0]), 32'd77);

`ifndef REGSEQ_SHADOW_EN
    // IN R7=45, MOVE 7->2 at RD_LAT=1
    issue(2'd0, 3'd0, 3'd7, 16'd45);
    @(negedge clock);
    issue(2'd1, 3'd7, 3'd2, 16'd0);
    chk("mv.rop", 32'(o_op), 32'd1);
    chk("mv.rcode", 32'(o_code), 32'd7);
    chk("mv.ren", 32'(o_en), 32'd1);
    @(negedge clock);
    chk("mv.wop", 32'(o_op), 32'd0);
    chk("mv.wcode", 32'(o_code), 32'd2);
    chk("mv.wdata", 32'(o_data), 32'd45);
    chk("mv.rdy", 32'(o_rdy), 32'd0);
    @(negedge clock);
    chk_idle("mv.end");
    chk("mv.cnt", 32'(o_cnt), 32'd3);
    chk("mv.mem", 32'(mem1[2]), 32'd45);

    // IN R4=30, OUT R4 at RD_LAT=3
    sel = 1'b0;
    issue(2'd0, 3'd0, 3'd4, 16'd30);
    @(negedge clock);
    issue(2'd2, 3'd4, 3'd0, 16'd0);
    chk("out.op", 32'(o_op), 32'd1);
    chk("out.code", 32'(o_code), 32'd4);
    for (int i = 1; i < 3; i++) begin
      @(negedge clock);
      chk("out.busy.rdy", 32'(o_rdy), 32'd0);
      chk("out.busy.rv", 32'(o_rv), 32'd0);
      chk("out.busy.op", 32'(o_op), 32'd1);
    end
    @(negedge clock);
    chk("out.rv", 32'(o_rv), 32'd1);
    chk("out.rd", 32'(o_rd), 32'd30);
    chk("out.rdy", 32'(o_rdy), 32'd1);
    chk("out.op3", 32'(o_op), 32'd3);
    @(negedge clock);
    chk("out.rv0", 32'(o_rv), 32'd0);
    @(negedge clock);
    chk("out.hold", 32'(o_rd), 32'd30);
    chk("out.cnt", 32'(o_cnt), 32'd2);

    // held valid across a MOVE 2->5 at RD_LAT=1
    sel = 1'b1;
    c0 = int'(cnt1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_src   = 3'd2;
    cmd_dst   = 3'd5;
    @(negedge clock);
    chk("hold.k.rdy", 32'(o_rdy), 32'd0);
    @(negedge clock);
    chk("hold.k1.rdy", 32'(o_rdy), 32'd0);
    @(negedge clock);
    chk("hold.k2.rdy", 32'(o_rdy), 32'd1);
    chk("hold.k2.cnt", 32'(o_cnt), 32'(c0 + 1));
    @(negedge clock);
    chk("hold.k3.rdy", 32'(o_rdy), 32'd0);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("hold.cnt", 32'(o_cnt), 32'(c0 + 2));
    chk("hold.mem", 32'(mem1[5]), 32'd45);

    // reset during the READ of a MOVE at RD_LAT=3
    sel = 1'b0;
    w0 = wr3;
    issue(2'd1, 3'd4, 3'd6, 16'd0);
    @(negedge clock);
    chk("rmv.op", 32'(o_op), 32'd1);
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    @(negedge clock);
    cmd_valid = 1'b0;
    reset     = 1'b0;
    chk_idle("rmv");
    chk("rmv.rd", 32'(o_rd), 32'd0);
    chk("rmv.cnt", 32'(o_cnt), 32'd0);
    repeat (4) @(negedge clock);
    chk("rmv.nowr", 32'(wr3), 32'(w0));
    chk("rmv.mem", 32'(mem3[6]), 32'd0);
    chk("rmv.cnt2", 32'(o_cnt), 32'd0);
`else
    // shadow: OUT answered in the acceptance cycle, no bank read
    sel = 1'b0;
    issue(2'd0, 3'd0, 3'd3, 16'h1234);
    @(negedge clock);
    issue(2'd2, 3'd3, 3'd0, 16'd0);
    chk("sh.rv", 32'(o_rv), 32'd1);
    chk("sh.rd", 32'(o_rd), 32'h1234);
    chk("sh.op", 32'(o_op), 32'd3);
    chk("sh.rdy", 32'(o_rdy), 32'd1);
    issue(2'd2, 3'd6, 3'd0, 16'd0);
    chk("sh.zero", 32'(o_rd), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
`endif

    // NOP then wrap of the command counter
    sel = 1'b1;
    issue(2'd3, 3'd0, 3'd0, 16'd0);
    chk_idle("nop");
    chk("nop.cnt", 32'(o_cnt), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    repeat (65535) @(negedge clock);
    cmd_valid = 1'b0;
    chk("wrap.cnt", 32'(o_cnt), 32'd0);
    @(negedge clock);
    chk("wrap.hold", 32'(o_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_cmd_sequencer.md
# reg_cmd_sequencer

Command initiator for the 8×16-bit register bank. Accepts IN / MOVE / OUT / NOP commands over a valid/ready port and drives the bank's code/data/op/enable interface, capturing bank read data through a read-latency counter. Sequences MOVE as a read phase followed by a write phase, so upstream logic never holds a temp value or hand-phases operations.

## Interface
Parameters:
- RD_LAT, 1: cycles from bank read request to rb_out valid; legal range 1–7.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; sampled on the clock edge.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept; high only in IDLE.
- cmd_op  in  2  0=IN, 1=MOVE, 2=OUT, 3=NOP.
- cmd_src  in  3  source register (MOVE, OUT).
- cmd_dst  in  3  destination register (IN, MOVE).
- cmd_data  in  16  immediate for IN.
- rb_code  out  3  bank register select.
- rb_data  out  16  bank write data.
- rb_op  out  2  bank op: 0=write, 1=read, 3=idle. The sequencer never drives 2.
- rb_enable  out  1  bank output enable.
- rb_out  in  16  bank read data.
- res_valid  out  1  one-cycle pulse; OUT result present.
- res_data  out  16  OUT result; holds until the next OUT.
- cmd_count  out  16  accepted-command counter; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, WRITE, READ, MOVE_WR. All rb_* and res_* outputs are registered.
- Handshake: a command is accepted on a clock edge where cmd_valid and cmd_ready are both high. cmd_count increments on every acceptance, NOP included.
- The command fields (op, src, dst, data) are latched at acceptance. Later changes to the inputs have no effect.
- IN: IDLE→WRITE. In WRITE: rb_op=0, rb_code=dst, rb_data=data for one cycle, then IDLE.
- MOVE: IDLE→READ. In READ: rb_op=1, rb_enable=1, rb_code=src for RD_LAT cycles. rb_out is captured into tmp on the final READ edge. Then MOVE_WR: rb_op=0, rb_code=dst, rb_data=tmp for one cycle, then IDLE.
- OUT: IDLE→READ exactly as MOVE. On the capture edge, res_data=rb_out and res_valid=1 for one cycle; the state returns to IDLE.
- NOP: accepted; stays IDLE; no bank activity.
- Idle bank drive (IDLE state and after reset): rb_op=3, rb_enable=0, rb_code=0, rb_data=0.
- MOVE with src==dst is executed normally: read, then write back the same value.

## Timing
- Reset values: cmd_ready=1 (state IDLE), rb_op=3, rb_enable=0, rb_code=0, rb_data=0, res_valid=0, res_data=0, cmd_count=0, tmp=0.
- Cycle k denotes the period after acceptance edge k.
- IN: bank write fields are driven in cycle k; the bank writes at edge k+1; cmd_ready=1 in cycle k+1. Throughput is one IN per 2 cycles.
- MOVE: the read is driven in cycles k…k+RD_LAT−1. The write is driven in cycle k+RD_LAT. cmd_ready returns in cycle k+RD_LAT+1.
- OUT: res_valid=1 in cycle k+RD_LAT, and cmd_ready=1 in that same cycle. This permits back-to-back OUT every RD_LAT+1 cycles.
- cmd_ready=0 in every non-IDLE cycle. A held cmd_valid is simply accepted later.
- Reset mid-operation: the in-flight command is aborted with no partial write. All outputs are at reset values in the cycle after the reset edge. Reset has priority over acceptance on the same edge.

## Configuration
- REGSEQ_SHADOW_EN defined: an internal 8×16 shadow copy is updated on every write the sequencer issues and is reset to 0.
  - MOVE and OUT read from the shadow; no bank read is issued.
  - MOVE: IDLE→MOVE_WR, with the write in cycle k.
  - OUT: res_valid in cycle k.
  - Registers never written through the sequencer read as 0.
- REGSEQ_SHADOW_EN undefined: bank read path only, as specified above.

## Structure
- Shared package regseq_pkg holds:
  - the cmd_op encodings (OP_IN, OP_MOVE, OP_OUT, OP_NOP);
  - the bank op encodings (RB_WRITE=0, RB_READ=1, RB_IDLE=3);
  - the FSM state enum.
- Sub-module regseq_shadow is the 8×16 shadow array with one write port and one read port. It is instantiated only under REGSEQ_SHADOW_EN.

## Test plan
- IN R0=77 accepted at edge k → cycle k: rb_op=0, rb_code=0, rb_data=77; cycle k+1: rb_op=3, cmd_ready=1, cmd_count=1.
- IN R7=45, then MOVE src=7 dst=2 (RD_LAT=1, bank model returns 45) → read in cycle k with rb_code=7, rb_enable=1; write in cycle k+1 with rb_code=2, rb_data=45.
- IN R4=30, then OUT src=4 (RD_LAT=3) → res_valid=1 and res_data=30 exactly in cycle k+3; res_data still 30 two cycles later.
- cmd_valid held high during a MOVE → cmd_ready=0 in every busy cycle; the second command is accepted only in IDLE, and cmd_count advances by exactly 2.
- Reset asserted during READ of a MOVE → no rb_op=0 cycle occurs; all outputs are at reset values, and cmd_count=0.
- REGSEQ_SHADOW_EN build: IN R3=0x1234, then OUT src=3 → res_valid in the acceptance cycle with 0x1234, and no rb_op=1 cycle occurs. Separately, 65 536 NOPs wrap cmd_count to 0.
